hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding unit for the pipelined MIPS core. It keeps its own shadow pipeline of in-flight register writers as (destination, Tnew) pairs and counts down each Tnew as instructions advance. Each cycle it compares that shadow state against the Tuse values of the instruction in ID to produce the stall and the ID-stage forward selects. An internal HI/LO busy counter models multiply/divide latency, so the core no longer depends on an external busy flag.

---
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_scoreboard.sv | 168 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard query bundle between the core pipeline and hazard_scoreboard.
// The core (master) drives the ID instruction fields and flush. The scoreboard
// (slave) returns the stall, the forward selects and the HI/LO status.
interface hazard_scoreboard_if #(
  parameter int TNEW_W = 2,
  parameter int FWD_W  = 2
);
  logic              id_valid;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [TNEW_W-1:0] id_tuse_rs;
  logic [TNEW_W-1:0] id_tuse_rt;
  logic [4:0]        id_rd;
  logic [TNEW_W-1:0] id_tnew;
  logic              id_md_start;
  logic              id_md_div;
  logic              id_md_use;
  logic              flush;

  logic              stall;
  logic [FWD_W-1:0]  fwd_rs;
  logic [FWD_W-1:0]  fwd_rt;
  logic              md_busy;
  logic [15:0]       stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_rd, id_tnew,
           id_md_start, id_md_div, id_md_use, flush,
    input  stall, fwd_rs, fwd_rt, md_busy, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_rd, id_tnew,
           id_md_start, id_md_div, id_md_use, flush,
    output stall, fwd_rs, fwd_rt, md_busy, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding unit for the pipelined MIPS core.
// Keeps a shadow pipeline of in-flight writers as (dst, tnew) pairs,
// compares it against the Tuse of the ID instruction to produce the stall
// and ID-stage forward selects, and models HI/LO busy time internally.
module hazard_scoreboard #(
  parameter int STAGES      = 3,
  parameter int TNEW_W      = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int FWD_W       = $clog2(STAGES + 1)
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave bus
);

  localparam int unsigned NSTG   = STAGES;
  localparam int          MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int          MD_W   = $clog2(MD_MAX + 1);
  localparam logic [MD_W-1:0] MULT_LOAD = MD_W'(MULT_CYCLES);
  localparam logic [MD_W-1:0] DIV_LOAD  = MD_W'(DIV_CYCLES);

  // ID fields after the id_valid qualifier
  logic [4:0]        rs_v;
  logic [4:0]        rt_v;
  logic [4:0]        rd_v;
  logic [TNEW_W-1:0] tuse_rs_v;
  logic [TNEW_W-1:0] tuse_rt_v;
  logic [TNEW_W-1:0] tnew_v;
  logic              md_start_v;
  logic              md_div_v;
  logic              md_use_v;

  // Shadow pipeline: index 0 = EX, increasing toward WB
  logic [4:0]        dst_q  [STAGES];
  logic [4:0]        dst_d  [STAGES];
  logic [TNEW_W-1:0] tnew_q [STAGES];
  logic [TNEW_W-1:0] tnew_d [STAGES];

  logic [MD_W-1:0]   md_cnt_q;
  logic [MD_W-1:0]   md_cnt_d;
  logic              md_busy_q;
  logic [15:0]       stall_cnt_q;
  logic [15:0]       stall_cnt_d;

  // Youngest-match lookup results
  logic              hit_rs;
  logic              hit_rt;
  logic [TNEW_W-1:0] win_tnew_rs;
  logic [TNEW_W-1:0] win_tnew_rt;
  logic [FWD_W-1:0]  win_sel_rs;
  logic [FWD_W-1:0]  win_sel_rt;

  logic              dstall_rs;
  logic              dstall_rt;
  logic              md_stall;
  logic              stall;
  logic              issue;

  // An invalid ID slot behaves as an all-zero instruction
  always_comb begin
    rs_v       = bus.id_valid ? bus.id_rs       : '0;
    rt_v       = bus.id_valid ? bus.id_rt       : '0;
    rd_v       = bus.id_valid ? bus.id_rd       : '0;
    tuse_rs_v  = bus.id_valid ? bus.id_tuse_rs  : '0;
    tuse_rt_v  = bus.id_valid ? bus.id_tuse_rt  : '0;
    tnew_v     = bus.id_valid ? bus.id_tnew     : '0;
    md_start_v = bus.id_valid & bus.id_md_start;
    md_div_v   = bus.id_valid & bus.id_md_div;
    md_use_v   = bus.id_valid & bus.id_md_use;
  end

  // Find the youngest in-flight writer of each source; the first hit scanning
  // from EX outward shadows every older writer of the same register
  always_comb begin
    hit_rs      = 1'b0;
    hit_rt      = 1'b0;
    win_tnew_rs = '0;
    win_tnew_rt = '0;
    win_sel_rs  = '0;
    win_sel_rt  = '0;
    for (int unsigned i = 0; i < NSTG; i++) begin
      if (!hit_rs && (rs_v != 5'd0) && (dst_q[i] == rs_v)) begin
        hit_rs      = 1'b1;
        win_tnew_rs = tnew_q[i];
        win_sel_rs  = FWD_W'(i + 1);
      end
      if (!hit_rt && (rt_v != 5'd0) && (dst_q[i] == rt_v)) begin
        hit_rt      = 1'b1;
        win_tnew_rt = tnew_q[i];
        win_sel_rt  = FWD_W'(i + 1);
      end
    end
  end

  // Stall decision and forward selects; flush always wins over stall
  always_comb begin
    dstall_rs = hit_rs && (win_tnew_rs > tuse_rs_v);
    dstall_rt = hit_rt && (win_tnew_rt > tuse_rt_v);
    md_stall  = md_use_v && md_busy_q;
    stall     = (dstall_rs || dstall_rt || md_stall) && !bus.flush;
    issue     = bus.id_valid && !stall && !bus.flush;
  end

  assign bus.stall       = stall;
  assign bus.fwd_rs      = (hit_rs && (win_tnew_rs == '0)) ? win_sel_rs : '0;
  assign bus.fwd_rt      = (hit_rt && (win_tnew_rt == '0)) ? win_sel_rt : '0;
  assign bus.md_busy     = md_busy_q;
  assign bus.stall_count = stall_cnt_q;

  // Next shadow state: insert the issuing writer (or a bubble) at EX and
  // age every older entry by one stage, counting its tnew down to zero
  always_comb begin
    for (int unsigned i = 0; i < NSTG; i++) begin
      dst_d[i]  = dst_q[i];
      tnew_d[i] = tnew_q[i];
    end
    if (bus.flush) begin
      for (int unsigned i = 0; i < NSTG; i++) begin
        dst_d[i]  = '0;
        tnew_d[i] = '0;
      end
    end else begin
      dst_d[0]  = issue ? rd_v   : '0;
      tnew_d[0] = issue ? tnew_v : '0;
      for (int unsigned i = 1; i < NSTG; i++) begin
        dst_d[i]  = dst_q[i-1];
        tnew_d[i] = (tnew_q[i-1] != '0) ? (tnew_q[i-1] - TNEW_W'(1)) : '0;
      end
    end
  end

  // HI/LO busy counter: loads only when an MD op really issues, never aborted
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (issue && md_start_v) begin
      md_cnt_d = md_div_v ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_W'(1);
    end
  end

  // Saturating count of stalled cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State registers; md_busy is kept as a flop tracking md_cnt != 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_q       <= '{default: '0};
      tnew_q      <= '{default: '0};
      md_cnt_q    <= '0;
      md_busy_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      dst_q       <= dst_d;
      tnew_q      <= tnew_d;
      md_cnt_q    <= md_cnt_d;
      md_busy_q   <= (md_cnt_d != '0);
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a table of per-cycle ID vectors
// with expected stall/forward values, plus hand sequences for MD latency,
// flush-versus-issue and asynchronous reset during a stall.
module tb_hazard_scoreboard;

  logic clk;
  logic rst_n;

  int tests;
  int failed;

  hazard_scoreboard_if #(.TNEW_W(2), .FWD_W(2)) bus ();

  hazard_scoreboard #(
    .STAGES      (3),
    .TNEW_W      (2),
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .FWD_W       (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] trs;
    logic [1:0] trt;
    logic [4:0] rd;
    logic [1:0] tnew;
    logic       fl;
    logic       st;
    logic [1:0] frs;
    logic [1:0] frt;
  } vec_t;

  typedef struct {
    logic       st;
    logic [1:0] frs;
    logic [1:0] frt;
  } exp_t;

  vec_t tbl [23];
  exp_t exp_q [$];

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [1:0] trs, input logic [1:0] trt,
                              input logic [4:0] rd, input logic [1:0] tnew, input logic fl,
                              input logic st, input logic [1:0] frs, input logic [1:0] frt);
    vec_t r;
    r.valid = v;  r.rs = rs;   r.rt = rt;   r.trs = trs; r.trt = trt;
    r.rd = rd;    r.tnew = tnew; r.fl = fl; r.st = st;   r.frs = frs; r.frt = frt;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] trs, input logic [1:0] trt,
                       input logic [4:0] rd, input logic [1:0] tnew,
                       input logic ms, input logic md, input logic mu, input logic fl);
    bus.id_valid    = v;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_tuse_rs  = trs;
    bus.id_tuse_rt  = trt;
    bus.id_rd       = rd;
    bus.id_tnew     = tnew;
    bus.id_md_start = ms;
    bus.id_md_div   = md;
    bus.id_md_use   = mu;
    bus.flush       = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // MD op followed immediately by an HI/LO reader; counts the reader's stall cycles
  task automatic md_seq(input logic is_div, input int exp_cycles, input string tag);
    int n;
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1, is_div, 1'b1, 1'b0);
    #2;
    check({tag, " start stall"}, int'(bus.stall), 0);
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    check({tag, " busy after start"}, int'(bus.md_busy), 1);
    n = 0;
    while (bus.stall && n < 40) begin
      n++;
      @(negedge clk);
      #2;
    end
    check({tag, " stall cycles"}, n, exp_cycles);
    check({tag, " busy at release"}, int'(bus.md_busy), 0);
    @(negedge clk);
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    tests  = 0;
    failed = 0;

    tbl[0]  = mk(1, 3, 5, 0, 0,  0, 0, 0,  0, 0, 0);
    tbl[1]  = mk(1, 1, 2, 1, 1,  3, 1, 0,  0, 0, 0);
    tbl[2]  = mk(1, 3, 0, 1, 0,  8, 1, 0,  0, 0, 0);
    tbl[3]  = mk(1, 3, 8, 0, 1,  0, 0, 0,  0, 2, 0);
    tbl[4]  = mk(1, 3, 8, 0, 0,  0, 0, 0,  0, 3, 2);
    tbl[5]  = mk(1, 8, 0, 1, 0,  5, 2, 0,  0, 3, 0);
    tbl[6]  = mk(1, 5, 5, 0, 0,  0, 0, 0,  1, 0, 0);
    tbl[7]  = mk(1, 5, 5, 0, 0,  0, 0, 0,  1, 0, 0);
    tbl[8]  = mk(1, 5, 5, 0, 0,  0, 0, 0,  0, 3, 3);
    tbl[9]  = mk(1, 0, 0, 0, 0,  0, 1, 0,  0, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 0,  7, 3, 0,  0, 0, 0);
    tbl[12] = mk(1, 0, 0, 0, 0,  7, 1, 0,  0, 0, 0);
    tbl[13] = mk(1, 0, 7, 0, 1,  0, 0, 0,  0, 0, 0);
    tbl[14] = mk(1, 7, 7, 0, 0,  0, 0, 0,  0, 2, 2);
    tbl[15] = mk(0, 7, 7, 0, 0,  9, 3, 0,  0, 0, 0);
    tbl[16] = mk(1, 9, 9, 0, 0,  0, 0, 0,  0, 0, 0);
    tbl[17] = mk(1, 0, 0, 0, 0,  4, 2, 0,  0, 0, 0);
    tbl[18] = mk(1, 4, 0, 0, 0,  6, 1, 1,  0, 0, 0);
    tbl[19] = mk(1, 4, 6, 0, 0,  0, 0, 0,  0, 0, 0);
    tbl[20] = mk(1, 0, 0, 0, 0, 10, 0, 0,  0, 0, 0);
    tbl[21] = mk(1,10, 0, 0, 0,  0, 0, 0,  0, 1, 0);
    tbl[22] = mk(1, 0,10, 0, 0,  0, 0, 0,  0, 0, 2);

    // Reset state with live-looking inputs
    rst_n = 1'b0;
    drive(1'b1, 5'd3, 5'd5, 2'd0, 2'd0, 5'd3, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    check("reset stall", int'(bus.stall), 0);
    check("reset fwd_rs", int'(bus.fwd_rs), 0);
    check("reset fwd_rt", int'(bus.fwd_rt), 0);
    check("reset md_busy", int'(bus.md_busy), 0);
    check("reset stall_count", int'(bus.stall_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Table-driven per-cycle vectors
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(tbl[i].valid, tbl[i].rs, tbl[i].rt, tbl[i].trs, tbl[i].trt,
            tbl[i].rd, tbl[i].tnew, 1'b0, 1'b0, 1'b0, tbl[i].fl);
      e.st = tbl[i].st; e.frs = tbl[i].frs; e.frt = tbl[i].frt;
      exp_q.push_back(e);
      #2;
      e = exp_q.pop_front();
      check($sformatf("row%0d stall", i), int'(bus.stall), int'(e.st));
      check($sformatf("row%0d fwd_rs", i), int'(bus.fwd_rs), int'(e.frs));
      check($sformatf("row%0d fwd_rt", i), int'(bus.fwd_rt), int'(e.frt));
    end

    @(negedge clk);
    idle();
    #2;
    check("stall_count after table", int'(bus.stall_count), 2);

    // MD latency: mult then mflo, div then mflo
    md_seq(1'b0, 5, "mult");
    md_seq(1'b1, 10, "div");
    #2;
    check("stall_count after md", int'(bus.stall_count), 17);

    // Flush on the same edge as an MD start and a writer issue: neither lands
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd12, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    check("flush+md stall", int'(bus.stall), 0);
    @(negedge clk);
    drive(1'b1, 5'd12, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    check("flush md_busy", int'(bus.md_busy), 0);
    check("flush reader stall", int'(bus.stall), 0);
    check("flush reader fwd_rs", int'(bus.fwd_rs), 0);

    // Asynchronous reset in the middle of an MD stall
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    check("pre-reset stall", int'(bus.stall), 1);
    rst_n = 1'b0;
    #1;
    check("async reset stall", int'(bus.stall), 0);
    check("async reset md_busy", int'(bus.md_busy), 0);
    check("async reset stall_count", int'(bus.stall_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    #2;
    check("post-reset stall", int'(bus.stall), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
